// File: rtl/stall_flush_pipe_if.sv
// Issue/writeback bundle for stall_flush_pipe: the issue slot, flush control and
// the pipeline observation outputs. The pipe takes the slave side.
interface stall_flush_pipe_if #(
    parameter int STAGES = 3,
    parameter int WIDTH  = 32,
    parameter int RA_W   = 5
);
    localparam int FD_W = $clog2(STAGES + 1);

    logic                    in_valid;
    logic [WIDTH-1:0]        in_data;
    logic [RA_W-1:0]         in_rd;
    logic                    in_rd_we;
    logic [RA_W-1:0]         in_rs1;
    logic [RA_W-1:0]         in_rs2;
    logic                    in_rs1_used;
    logic                    in_rs2_used;
    logic                    flush;
    logic [FD_W-1:0]         flush_depth;
    logic                    in_ready;
    logic                    hazard;
    logic [STAGES-1:0]       stage_valid;
    logic [STAGES*WIDTH-1:0] stage_data;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [RA_W-1:0]         out_rd;
    logic                    out_rd_we;
    logic [15:0]             stall_count;

    modport master (
        output in_valid, in_data, in_rd, in_rd_we, in_rs1, in_rs2,
               in_rs1_used, in_rs2_used, flush, flush_depth,
        input  in_ready, hazard, stage_valid, stage_data,
               out_valid, out_data, out_rd, out_rd_we, stall_count
    );

    modport slave (
        input  in_valid, in_data, in_rd, in_rd_we, in_rs1, in_rs2,
               in_rs1_used, in_rs2_used, flush, flush_depth,
        output in_ready, hazard, stage_valid, stage_data,
               out_valid, out_data, out_rd, out_rd_we, stall_count
    );
endinterface

// File: rtl/stall_flush_pipe.sv
// Fixed-advance in-order pipeline with RAW interlock at issue and depth-limited
// flush of the youngest stages; the last stage is the writeback slot.
module stall_flush_pipe #(
    parameter int STAGES = 3,
    parameter int WIDTH  = 32,
    parameter int RA_W   = 5
) (
    input logic               clk,
    input logic               reset,
    stall_flush_pipe_if.slave bus
);
    localparam int              FD_W      = $clog2(STAGES + 1);
    localparam logic [FD_W-1:0] DEPTH_MAX = FD_W'(STAGES);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [FD_W-1:0] clamp_depth(input logic [FD_W-1:0] d);
        return (d > DEPTH_MAX) ? DEPTH_MAX : d;
    endfunction

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] we_q;
    logic [RA_W-1:0]   rd_q   [STAGES];
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [15:0]       stall_q;

    logic              haz;
    logic              accept;
    logic [FD_W-1:0]   depth;
    logic [STAGES-2:0] kill;

    // Writeback stage is excluded: the register file forwards its write.
    always_comb begin
        haz = 1'b0;
        for (int k = 0; k < STAGES - 1; k++) begin
            if (vld_q[k] && we_q[k] && (rd_q[k] != '0)) begin
                if (bus.in_rs1_used && (bus.in_rs1 == rd_q[k])) haz = 1'b1;
                if (bus.in_rs2_used && (bus.in_rs2 == rd_q[k])) haz = 1'b1;
            end
        end
        haz = haz & bus.in_valid;
    end

    always_comb begin
        depth = clamp_depth(bus.flush_depth);
        kill  = '0;
        for (int k = 0; k < STAGES - 1; k++) begin
            kill[k] = bus.flush && (FD_W'(k) < depth);
        end
    end

    assign accept = bus.in_valid & ~haz & ~bus.flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q   <= '0;
            we_q    <= '0;
            stall_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                rd_q[k]   <= '0;
                data_q[k] <= '0;
            end
        end else begin
            // Stage 0: accepted instruction or a bubble.
            vld_q[0]  <= accept;
            we_q[0]   <= accept & bus.in_rd_we;
            rd_q[0]   <= bus.in_rd;
            data_q[0] <= bus.in_data;
            // Stages 1..STAGES-1: unconditional shift, killed entries lose valid and rd_we.
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k]  <= vld_q[k-1] & ~kill[k-1];
                we_q[k]   <= we_q[k-1] & ~kill[k-1];
                rd_q[k]   <= rd_q[k-1];
                data_q[k] <= data_q[k-1];
            end
            if (haz && !bus.flush) stall_q <= sat_inc(stall_q);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage_data
        assign bus.stage_data[k*WIDTH +: WIDTH] = data_q[k];
    end

    assign bus.hazard      = haz;
    assign bus.in_ready    = ~haz;
    assign bus.stage_valid = vld_q;
    assign bus.out_valid   = vld_q[STAGES-1];
    assign bus.out_data    = data_q[STAGES-1];
    assign bus.out_rd      = rd_q[STAGES-1];
    assign bus.out_rd_we   = we_q[STAGES-1];
    assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_stall_flush_pipe.sv
// Directed bench for stall_flush_pipe: a 3-stage instance for function and a
// deep 8-stage instance for stall-counter saturation.
module tb_stall_flush_pipe;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    stall_flush_pipe_if #(.STAGES(3), .WIDTH(32), .RA_W(5)) bus ();
    stall_flush_pipe_if #(.STAGES(8), .WIDTH(32), .RA_W(5)) bus8 ();

    stall_flush_pipe #(.STAGES(3), .WIDTH(32), .RA_W(5)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );
    stall_flush_pipe #(.STAGES(8), .WIDTH(32), .RA_W(5)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_data = '0; bus.in_rd = '0; bus.in_rd_we = 0;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rs1_used = 0; bus.in_rs2_used = 0;
        bus.flush = 0; bus.flush_depth = '0;
    endtask

    task automatic drive(input logic [31:0] d, input logic [4:0] rd, input logic we,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
        bus.in_valid = 1; bus.in_data = d; bus.in_rd = rd; bus.in_rd_we = we;
        bus.in_rs1 = rs1; bus.in_rs1_used = u1; bus.in_rs2 = rs2; bus.in_rs2_used = u2;
        bus.flush = 0; bus.flush_depth = '0;
    endtask

    task automatic test_reset();
        idle();
        #2;
        total++; if (bus.stage_valid !== 3'b000) begin bad++; $display("FAIL reset_stage_valid got=%b exp=000", bus.stage_valid); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.stall_count !== 16'd0) begin bad++; $display("FAIL reset_stall_count got=%0d exp=0", bus.stall_count); end
        total++; if (bus.in_ready !== 1'b1 || bus.hazard !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b/%b exp=1/0", bus.in_ready, bus.hazard); end
        tick();
        total++; if (bus.stage_data !== 96'h0) begin bad++; $display("FAIL reset_stage_data got=%h exp=0", bus.stage_data); end
        reset = 1'b1;
    endtask

    task automatic test_raw_hazard();
        drive(32'h100, 5'd5, 1, 5'd0, 0, 5'd0, 0);
        tick();
        drive(32'h200, 5'd6, 1, 5'd5, 1, 5'd0, 0);
        #1;
        total++; if (bus.hazard !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL raw_c0 got=%b/%b exp=1/0", bus.hazard, bus.in_ready); end
        tick();
        total++; if (bus.hazard !== 1'b1 || bus.stage_valid !== 3'b010) begin bad++; $display("FAIL raw_c1 got=%b/%b exp=1/010", bus.hazard, bus.stage_valid); end
        total++; if (bus.stall_count !== 16'd1) begin bad++; $display("FAIL raw_count1 got=%0d exp=1", bus.stall_count); end
        tick();
        total++; if (bus.hazard !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL raw_c2 got=%b/%b exp=0/1", bus.hazard, bus.in_ready); end
        total++; if (bus.stage_valid !== 3'b100) begin bad++; $display("FAIL raw_c2_valid got=%b exp=100", bus.stage_valid); end
        tick();
        idle();
        total++; if (bus.stage_valid !== 3'b001 || bus.stage_data[31:0] !== 32'h200) begin bad++; $display("FAIL raw_enter got=%b/%h exp=001/200", bus.stage_valid, bus.stage_data[31:0]); end
        total++; if (bus.stall_count !== 16'd2) begin bad++; $display("FAIL raw_count2 got=%0d exp=2", bus.stall_count); end
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        drive(32'h11, 5'd1, 1, 5'd7, 1, 5'd0, 0);
        #1;
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL b2b_haz0 got=%b exp=0", bus.hazard); end
        tick();
        drive(32'h22, 5'd2, 1, 5'd7, 1, 5'd9, 1);
        #1;
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL b2b_haz1 got=%b exp=0", bus.hazard); end
        tick();
        drive(32'h33, 5'd3, 1, 5'd1, 0, 5'd2, 0);
        #1;
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL b2b_haz_unused got=%b exp=0", bus.hazard); end
        tick();
        idle();
        total++; if (bus.stage_valid !== 3'b111 || bus.stage_data !== 96'h00000011_00000022_00000033) begin bad++; $display("FAIL b2b_full got=%b/%h exp=111/000000110000002200000033", bus.stage_valid, bus.stage_data); end
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11 || bus.out_rd !== 5'd1 || bus.out_rd_we !== 1'b1) begin bad++; $display("FAIL b2b_out0 got=%b/%h/%0d/%b exp=1/11/1/1", bus.out_valid, bus.out_data, bus.out_rd, bus.out_rd_we); end
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h22) begin bad++; $display("FAIL b2b_out1 got=%b/%h exp=1/22", bus.out_valid, bus.out_data); end
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h33) begin bad++; $display("FAIL b2b_out2 got=%b/%h exp=1/33", bus.out_valid, bus.out_data); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_flush();
        drive(32'hA, 5'd1, 1, 5'd0, 0, 5'd0, 0); tick();
        drive(32'hB, 5'd2, 1, 5'd0, 0, 5'd0, 0); tick();
        drive(32'hC, 5'd3, 1, 5'd0, 0, 5'd0, 0); tick();
        drive(32'hD, 5'd4, 1, 5'd0, 0, 5'd0, 0);
        bus.flush = 1; bus.flush_depth = 2'd2;
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA) begin bad++; $display("FAIL flush_retire got=%b/%h exp=1/a", bus.out_valid, bus.out_data); end
        tick();
        idle();
        total++; if (bus.stage_valid !== 3'b000 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_d2 got=%b/%b exp=000/0", bus.stage_valid, bus.out_valid); end
        // Killed entries still hold rd 2 and 3; they must not interlock.
        drive(32'hE, 5'd8, 1, 5'd2, 1, 5'd3, 1);
        #1;
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL flush_dead_rd got=%b exp=0", bus.hazard); end
        idle();
        drive(32'h21, 5'd6, 1, 5'd0, 0, 5'd0, 0); tick();
        drive(32'h22, 5'd7, 1, 5'd0, 0, 5'd0, 0); tick();
        idle();
        bus.flush = 1; bus.flush_depth = 2'd1;
        tick();
        idle();
        total++; if (bus.stage_valid !== 3'b100 || bus.out_data !== 32'h21) begin bad++; $display("FAIL flush_d1 got=%b/%h exp=100/21", bus.stage_valid, bus.out_data); end
        tick();
        drive(32'h30, 5'd8, 1, 5'd0, 0, 5'd0, 0); tick();
        drive(32'h31, 5'd9, 1, 5'd8, 1, 5'd0, 0);
        bus.flush = 1; bus.flush_depth = 2'd0;
        #1;
        total++; if (bus.hazard !== 1'b1) begin bad++; $display("FAIL flush_haz_seen got=%b exp=1", bus.hazard); end
        tick();
        idle();
        total++; if (bus.stage_valid !== 3'b010) begin bad++; $display("FAIL flush_d0 got=%b exp=010", bus.stage_valid); end
        total++; if (bus.stall_count !== 16'd2) begin bad++; $display("FAIL flush_no_count got=%0d exp=2", bus.stall_count); end
        repeat (2) tick();
    endtask

    task automatic test_x0_and_writeback();
        drive(32'h40, 5'd0, 1, 5'd0, 0, 5'd0, 0); tick();
        drive(32'h41, 5'd11, 1, 5'd0, 1, 5'd0, 1);
        #1;
        total++; if (bus.hazard !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL x0_haz got=%b/%b exp=0/1", bus.hazard, bus.in_ready); end
        tick();
        idle();
        tick();
        drive(32'h42, 5'd12, 1, 5'd0, 0, 5'd11, 1);
        #1;
        total++; if (bus.hazard !== 1'b1) begin bad++; $display("FAIL rs2_haz got=%b exp=1", bus.hazard); end
        bus.in_valid = 0;
        #1;
        total++; if (bus.hazard !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL novalid_haz got=%b/%b exp=0/1", bus.hazard, bus.in_ready); end
        idle();
        tick();
        drive(32'h43, 5'd13, 1, 5'd11, 1, 5'd0, 0);
        #1;
        total++; if (bus.out_rd !== 5'd11 || bus.hazard !== 1'b0) begin bad++; $display("FAIL wb_excluded got=%0d/%b exp=11/0", bus.out_rd, bus.hazard); end
        idle();
        tick();
        total++; if (bus.stall_count !== 16'd2) begin bad++; $display("FAIL x0_count got=%0d exp=2", bus.stall_count); end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        drive(32'h51, 5'd12, 1, 5'd0, 0, 5'd0, 0); tick();
        drive(32'h52, 5'd13, 1, 5'd0, 0, 5'd0, 0); tick();
        drive(32'h53, 5'd14, 1, 5'd0, 0, 5'd0, 0); tick();
        idle();
        total++; if (bus.stage_valid !== 3'b111) begin bad++; $display("FAIL rmid_filled got=%b exp=111", bus.stage_valid); end
        reset = 1'b0;
        #1;
        total++; if (bus.stage_valid !== 3'b000 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b/%b exp=000/0", bus.stage_valid, bus.out_valid); end
        total++; if (bus.stall_count !== 16'd0 || bus.out_data !== 32'h0) begin bad++; $display("FAIL rmid_clear got=%0d/%h exp=0/0", bus.stall_count, bus.out_data); end
        tick();
        reset = 1'b1;
        drive(32'h60, 5'd15, 1, 5'd0, 0, 5'd0, 0);
        tick();
        idle();
        total++; if (bus.stage_valid !== 3'b001 || bus.stage_data[31:0] !== 32'h60) begin bad++; $display("FAIL rmid_first got=%b/%h exp=001/60", bus.stage_valid, bus.stage_data[31:0]); end
        repeat (3) tick();
    endtask

    task automatic test_saturation();
        int cycles;
        // A self-dependent instruction re-issued forever stalls 7 of every 8 cycles.
        bus8.in_valid = 1; bus8.in_data = 32'h70; bus8.in_rd = 5'd5; bus8.in_rd_we = 1;
        bus8.in_rs1 = 5'd5; bus8.in_rs1_used = 1;
        cycles = 0;
        while (cycles < 80000 && bus8.stall_count !== 16'hFFFF) begin
            tick();
            cycles++;
        end
        total++; if (bus8.stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h exp=ffff after %0d cycles", bus8.stall_count, cycles); end
        total++; if (cycles < 65535) begin bad++; $display("FAIL sat_too_fast got=%0d cycles exp>=65535", cycles); end
        repeat (20) tick();
        total++; if (bus8.stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", bus8.stall_count); end
        bus8.in_valid = 0; bus8.in_rs1_used = 0;
        tick();
    endtask

    initial begin
        bus8.in_valid = 0; bus8.in_data = '0; bus8.in_rd = '0; bus8.in_rd_we = 0;
        bus8.in_rs1 = '0; bus8.in_rs2 = '0; bus8.in_rs1_used = 0; bus8.in_rs2_used = 0;
        bus8.flush = 0; bus8.flush_depth = '0;
        test_reset();
        test_raw_hazard();
        test_back_to_back();
        test_flush();
        test_x0_and_writeback();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
